// File: rtl/msg_sender.sv
// Turns length-prefixed commands plus a raw payload word stream into AXI-Stream
// beats with byte keep, zero-filled tail bytes and a one-cycle msg_done pulse.
module msg_sender #(
  parameter int NUM_COUNT_BITS = 16,
  parameter int TKEEP_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [NUM_COUNT_BITS-1:0]  cmd_length,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*TKEEP_WIDTH-1:0]   in_data,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [8*TKEEP_WIDTH-1:0]   m_tdata,
  output logic [TKEEP_WIDTH-1:0]     m_tkeep,
  output logic                       m_tlast,
  output logic                       msg_done
);

  localparam logic [NUM_COUNT_BITS:0]   KW_EXT = (NUM_COUNT_BITS+1)'(TKEEP_WIDTH);
  localparam logic [NUM_COUNT_BITS-1:0] KW     = NUM_COUNT_BITS'(TKEEP_WIDTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     r_state, w_state_nxt;
  logic [NUM_COUNT_BITS-1:0]  r_remaining;
  logic [NUM_COUNT_BITS:0]    w_rem_ext;
  logic                       w_cmd_hs, w_in_hs, w_out_hs, w_last;
  logic [TKEEP_WIDTH-1:0]     w_keep;
  logic [8*TKEEP_WIDTH-1:0]   w_data;

  assign w_rem_ext = {1'b0, r_remaining};
  assign w_last    = (w_rem_ext <= KW_EXT);
  assign cmd_ready = rst && (r_state == IDLE);
  // Single-entry output register: accept a word only if the slot is free or draining now.
  assign in_ready  = rst && (r_state == SEND) && (!m_tvalid || m_tready);
  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = m_tvalid && m_tready;

  for (genvar g = 0; g < TKEEP_WIDTH; g++) begin : g_lane
    assign w_keep[g]         = !w_last || (w_rem_ext > (NUM_COUNT_BITS+1)'(g));
    assign w_data[8*g +: 8]  = w_keep[g] ? in_data[8*g +: 8] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs && (cmd_length != '0)) w_state_nxt = SEND;
      SEND:    if (w_in_hs && w_last)              w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_remaining <= '0;
    end else if (w_cmd_hs) begin
      r_remaining <= cmd_length;
    end else if (w_in_hs) begin
      r_remaining <= w_last ? '0 : (r_remaining - KW);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      if (w_in_hs) begin
        m_tvalid <= 1'b1;
        m_tdata  <= w_data;
        m_tkeep  <= w_keep;
        m_tlast  <= w_last;
      end else if (w_out_hs) begin
        m_tvalid <= 1'b0;
      end
      msg_done <= w_out_hs && m_tlast;
    end
  end

endmodule

// File: tb/tb_msg_sender.sv
// Randomized self-checking bench for msg_sender: beats are predicted from the
// message length alone (beat count, bytes per beat) and compared to the captured stream.
module tb_msg_sender;
  localparam int NCB = 16;
  localparam int K   = 8;
  localparam int DW  = 8*K;

  typedef struct packed {
    logic          last;
    logic [K-1:0]  keep;
    logic [DW-1:0] data;
  } beat_t;

  logic           clk = 1'b0, rst = 1'b0;
  logic           cmd_valid = 1'b0, cmd_ready;
  logic [NCB-1:0] cmd_length = '0;
  logic           in_valid = 1'b0, in_ready;
  logic [DW-1:0]  in_data = '0;
  logic           m_tvalid, m_tready, m_tlast, msg_done;
  logic [DW-1:0]  m_tdata;
  logic [K-1:0]   m_tkeep;

  logic tr_rand_en = 1'b0, tr_rand = 1'b1, tr_force = 1'b1;
  assign m_tready = tr_rand_en ? tr_rand : tr_force;

  int     checks = 0, errors = 0, done_cnt = 0;
  longint cyc = 0;
  bit     drv_to = 0;
  logic   prev_last_hs = 1'b0;
  beat_t  got[$], exp_q[$];

  msg_sender #(.NUM_COUNT_BITS(NCB), .TKEEP_WIDTH(K)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1 tr_rand = ($urandom_range(0, 3) != 0);
  end

  // Stream capture; msg_done must follow each last-beat handshake by exactly one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_last_hs = 1'b0;
    end else begin
      checks++;
      if (msg_done !== prev_last_hs) begin
        $display("FAIL msg_done_timing: got %b want %b at %0t", msg_done, prev_last_hs, $time);
        errors++;
      end
      if (msg_done === 1'b1) done_cnt++;
      prev_last_hs = m_tvalid && m_tready && m_tlast;
      if (m_tvalid && m_tready) got.push_back(beat_t'({m_tlast, m_tkeep, m_tdata}));
    end
  end

  // Beat k of a len-byte message carries min(K, len-k*K) bytes.
  function automatic beat_t model_beat(input int len, input int k, input logic [DW-1:0] w);
    beat_t b;
    int    nb;
    nb = len - k*K;
    if (nb > K) nb = K;
    b.last = ((k+1)*K >= len);
    b.keep = K'((1 << nb) - 1);
    for (int i = 0; i < K; i++) b.data[8*i +: 8] = (i < nb) ? w[8*i +: 8] : 8'h00;
    return b;
  endfunction

  task automatic send_cmd(input int len);
    bit hs = 0;
    cmd_valid = 1'b1;
    cmd_length = NCB'(len);
    for (int n = 0; n < 2000 && !hs; n++) begin
      @(negedge clk); hs = cmd_ready;
      @(posedge clk); #1;
    end
    if (!hs) drv_to = 1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed_word(input logic [DW-1:0] w, input int gap);
    bit hs = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 2000 && !hs; n++) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
    end
    if (!hs) drv_to = 1;
  endtask

  task automatic run_msg(input int len, input int max_gap);
    logic [DW-1:0] w;
    int nbeats;
    send_cmd(len);
    nbeats = (len + K - 1) / K;
    for (int k = 0; k < nbeats; k++) begin
      w = {$urandom, $urandom};
      exp_q.push_back(model_beat(len, k, w));
      feed_word(w, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int n = 0; n < 20000; n++) begin
      if (got.size() >= exp_q.size()) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    ok = ok && !drv_to;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, msg_done, in_ready, cmd_ready} !== '0) begin
      $display("FAIL reset_outputs: got tv=%b d=%h k=%h l=%b done=%b ir=%b cr=%b want all 0",
               m_tvalid, m_tdata, m_tkeep, m_tlast, msg_done, in_ready, cmd_ready);
      errors++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL reset_first_cmd_ready: got %b want 1", cmd_ready); errors++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat;
    bit ok; int d0;
    got.delete(); exp_q.delete(); d0 = done_cnt; tr_force = 1'b1;
    run_msg(8, 0);
    wait_drain(ok);
    checks++; if (!ok) begin $display("FAIL single_timeout: got %0d beats want %0d", got.size(), exp_q.size()); errors++; end
    checks++; if (got.size() !== 1) begin $display("FAIL single_count: got %0d want 1", got.size()); errors++; end
    if (got.size() > 0) begin
      checks++; if (got[0] !== exp_q[0]) begin $display("FAIL single_beat: got %h want %h", got[0], exp_q[0]); errors++; end
      checks++; if ({got[0].last, got[0].keep} !== {1'b1, 8'hFF}) begin
        $display("FAIL single_keep_last: got %b/%h want 1/ff", got[0].last, got[0].keep); errors++; end
    end
    checks++; if (done_cnt !== d0 + 1) begin $display("FAIL single_done: got %0d want %0d", done_cnt - d0, 1); errors++; end
  endtask

  task automatic test_partial;
    bit ok;
    got.delete(); exp_q.delete(); tr_force = 1'b1;
    run_msg(13, 0);
    wait_drain(ok);
    checks++; if (!ok || got.size() !== 2) begin $display("FAIL partial_count: got %0d want 2", got.size()); errors++; end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin $display("FAIL partial_beat%0d: got %h want %h", i, got[i], exp_q[i]); errors++; end
    end
    if (got.size() == 2) begin
      checks++; if ({got[0].last, got[0].keep, got[1].last, got[1].keep} !== {1'b0, 8'hFF, 1'b1, 8'h1F}) begin
        $display("FAIL partial_keep: got %b/%h %b/%h want 0/ff 1/1f", got[0].last, got[0].keep, got[1].last, got[1].keep); errors++; end
      checks++; if (got[1].data[63:40] !== 24'h0) begin
        $display("FAIL partial_zero_fill: got %h want 000000", got[1].data[63:40]); errors++; end
    end
  endtask

  task automatic test_zero_len;
    bit ok; int d0;
    got.delete(); exp_q.delete(); d0 = done_cnt; tr_force = 1'b1;
    run_msg(0, 0);
    @(negedge clk);
    checks++; if ({cmd_ready, m_tvalid} !== 2'b10) begin
      $display("FAIL zero_state: got cmd_ready=%b tvalid=%b want 1/0", cmd_ready, m_tvalid); errors++; end
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    wait_drain(ok);
    checks++; if (!ok || got.size() !== 0) begin $display("FAIL zero_beats: got %0d want 0", got.size()); errors++; end
    checks++; if (done_cnt !== d0) begin $display("FAIL zero_done: got %0d want 0", done_cnt - d0); errors++; end
  endtask

  task automatic test_stall;
    bit ok;
    logic [DW-1:0] w[3];
    got.delete(); exp_q.delete(); tr_force = 1'b1;
    for (int i = 0; i < 3; i++) begin w[i] = {$urandom, $urandom}; exp_q.push_back(model_beat(24, i, w[i])); end
    send_cmd(24);
    feed_word(w[0], 0);
    feed_word(w[1], 0);
    tr_force = 1'b0;
    in_data = w[2];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({in_ready, m_tvalid} !== 2'b01) begin
        $display("FAIL stall_ready%0d: got in_ready=%b tvalid=%b want 0/1", c, in_ready, m_tvalid); errors++; end
      checks++; if (beat_t'({m_tlast, m_tkeep, m_tdata}) !== exp_q[1]) begin
        $display("FAIL stall_hold%0d: got %h want %h", c, beat_t'({m_tlast, m_tkeep, m_tdata}), exp_q[1]); errors++; end
      @(posedge clk); #1;
    end
    tr_force = 1'b1;
    feed_word(w[2], 0);
    in_valid = 1'b0;
    wait_drain(ok);
    checks++; if (!ok || got.size() !== 3) begin $display("FAIL stall_count: got %0d want 3", got.size()); errors++; end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin $display("FAIL stall_beat%0d: got %h want %h", i, got[i], exp_q[i]); errors++; end
    end
    if (got.size() == 3) begin
      checks++; if ({got[2].last, got[2].keep} !== {1'b1, 8'hFF}) begin
        $display("FAIL stall_last_keep: got %b/%h want 1/ff", got[2].last, got[2].keep); errors++; end
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int d0; longint c0;
    logic [K-1:0] keeps [3];
    keeps[0] = 8'h07; keeps[1] = 8'hFF; keeps[2] = 8'h01;
    got.delete(); exp_q.delete(); d0 = done_cnt; tr_force = 1'b1;
    c0 = cyc;
    run_msg(3, 0);
    run_msg(9, 0);
    checks++; if (cyc - c0 !== 5) begin $display("FAIL b2b_cycles: got %0d want 5", cyc - c0); errors++; end
    wait_drain(ok);
    checks++; if (!ok || got.size() !== 3) begin $display("FAIL b2b_count: got %0d want 3", got.size()); errors++; end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin $display("FAIL b2b_beat%0d: got %h want %h", i, got[i], exp_q[i]); errors++; end
      checks++; if (got[i].keep !== keeps[i]) begin $display("FAIL b2b_keep%0d: got %h want %h", i, got[i].keep, keeps[i]); errors++; end
    end
    checks++; if (done_cnt !== d0 + 2) begin $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); errors++; end
  endtask

  task automatic test_reset_mid;
    bit ok; int d0;
    got.delete(); exp_q.delete(); tr_force = 1'b0;
    send_cmd(20);
    feed_word({$urandom, $urandom}, 0);
    in_valid = 1'b0;
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    checks++; if ({m_tvalid, m_tkeep, m_tlast, in_ready, cmd_ready} !== '0) begin
      $display("FAIL midrst_outputs: got tv=%b k=%h l=%b ir=%b cr=%b want 0", m_tvalid, m_tkeep, m_tlast, in_ready, cmd_ready); errors++; end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; tr_force = 1'b1;
    checks++; if (got.size() !== 0) begin $display("FAIL midrst_no_beat: got %0d want 0", got.size()); errors++; end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); errors++; end
    @(posedge clk); #1;
    got.delete(); exp_q.delete();
    run_msg(1, 0);
    wait_drain(ok);
    checks++; if (!ok || got.size() !== 1) begin $display("FAIL midrst_count: got %0d want 1", got.size()); errors++; end
    if (got.size() == 1) begin
      checks++; if (got[0] !== exp_q[0] || {got[0].last, got[0].keep} !== {1'b1, 8'h01}) begin
        $display("FAIL midrst_beat: got %h want %h", got[0], exp_q[0]); errors++; end
    end
    checks++; if (done_cnt !== d0 + 1) begin $display("FAIL midrst_done: got %0d want 1", done_cnt - d0); errors++; end
  endtask

  task automatic test_random;
    bit ok; int d0, nmsg, len, sel;
    got.delete(); exp_q.delete(); d0 = done_cnt; nmsg = 0;
    tr_rand_en = 1'b1;
    for (int m = 0; m < 25; m++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 0;
      else if (sel < 4)  len = 8 * $urandom_range(1, 5);
      else               len = $urandom_range(1, 70);
      if (len != 0) nmsg++;
      run_msg(len, 2);
    end
    wait_drain(ok);
    tr_rand_en = 1'b0;
    checks++; if (!ok || got.size() !== exp_q.size()) begin
      $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); errors++; end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin $display("FAIL rand_beat%0d: got %h want %h", i, got[i], exp_q[i]); errors++; end
    end
    checks++; if (done_cnt !== d0 + nmsg) begin $display("FAIL rand_done: got %0d want %0d", done_cnt - d0, nmsg); errors++; end
  endtask

  task automatic test_max_len;
    bit ok; int nbad;
    got.delete(); exp_q.delete(); tr_force = 1'b1; nbad = 0;
    run_msg(65535, 0);
    wait_drain(ok);
    checks++; if (!ok || got.size() !== 8192) begin $display("FAIL max_count: got %0d want 8192", got.size()); errors++; end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) nbad++;
    checks++; if (nbad !== 0) begin $display("FAIL max_beats: got %0d bad beats want 0", nbad); errors++; end
    if (got.size() == 8192) begin
      checks++; if ({got[8191].last, got[8191].keep} !== {1'b1, 8'h7F}) begin
        $display("FAIL max_last: got %b/%h want 1/7f", got[8191].last, got[8191].keep); errors++; end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_partial();
    test_zero_len();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_sender.md
MSG_SENDER -- requirements
Module: msg_sender

Interface
REQ-001 The block SHALL have parameter NUM_COUNT_BITS, default 16, giving the width of the message length in bytes.
REQ-002 The block SHALL have parameter TKEEP_WIDTH, default 8, giving the bytes per beat; data width is 8*TKEEP_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: a message command is offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the command is accepted.
REQ-007 The block SHALL have port cmd_length, input, NUM_COUNT_BITS bits: message length in bytes.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a payload word is offered.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the payload word is accepted.
REQ-010 The block SHALL have port in_data, input, 8*TKEEP_WIDTH bits: payload word, byte 0 in bits [7:0].
REQ-011 The block SHALL have AXI-Stream master ports m_tvalid (output, 1), m_tready (input, 1), m_tdata (output, 8*TKEEP_WIDTH), m_tkeep (output, TKEEP_WIDTH) and m_tlast (output, 1).
REQ-012 The block SHALL have port msg_done, output, 1 bit: one-cycle pulse when a message is fully sent.

Function
REQ-013 The block SHALL implement two states, IDLE and SEND, plus a remaining-bytes register of NUM_COUNT_BITS bits.
REQ-014 The block SHALL drive cmd_ready = 1 only in IDLE with rst high; a command handshake is cmd_valid && cmd_ready.
REQ-015 On a command handshake with cmd_length != 0, the block SHALL load remaining with cmd_length and enter SEND on the next edge.
REQ-016 On a command handshake with cmd_length == 0, the block SHALL stay in IDLE, emit no beat and not pulse msg_done.
REQ-017 The block SHALL hold in_ready at 0 in IDLE; in SEND, in_ready SHALL equal (!m_tvalid || m_tready), so the output register is a single entry.
REQ-018 On each in_valid && in_ready handshake, the block SHALL load the output register on the same edge and set m_tvalid = 1 (latency one cycle from in_data to m_tdata).
REQ-019 For a beat with remaining > TKEEP_WIDTH, the block SHALL set m_tkeep to all ones and m_tlast to 0, and SHALL reduce remaining by TKEEP_WIDTH.
REQ-020 For a beat with remaining <= TKEEP_WIDTH (the last beat), the block SHALL set m_tkeep to the lowest "remaining" bits set and m_tlast to 1.
REQ-021 On the last beat, the block SHALL zero the m_tdata bytes whose m_tkeep bit is 0.
REQ-022 On the last beat, the block SHALL return to IDLE on the same edge, so the next command can be accepted while that beat is still pending.
REQ-023 The number of beats per message SHALL be ceil(cmd_length/TKEEP_WIDTH); the maximum is ceil((2^NUM_COUNT_BITS-1)/TKEEP_WIDTH), with no overflow or wrap-around.
REQ-024 While m_tvalid = 1 and m_tready = 0, the block SHALL hold m_tdata, m_tkeep and m_tlast stable.
REQ-025 The block SHALL clear m_tvalid on an output handshake unless a new word is loaded on the same edge.
REQ-026 The block SHALL register msg_done high for exactly one cycle after the edge on which m_tvalid && m_tready && m_tlast.
REQ-027 With in_valid and m_tready held high, the block SHALL sustain one beat per cycle, with back-to-back messages separated only by the one-cycle IDLE command slot.

Reset
REQ-028 While rst = 0, the block SHALL force state = IDLE, remaining = 0, and all outputs to 0: m_tvalid, m_tdata, m_tkeep, m_tlast, msg_done, in_ready and cmd_ready.
REQ-029 Reset asserted mid-message SHALL immediately discard the pending beat and the rest of the message, with no msg_done.
REQ-030 After rst deasserts, the block SHALL accept a new command in the first cycle.

Verification
REQ-031 cmd_length=8 -> one beat with m_tkeep=0xFF, m_tlast=1, msg_done pulses once.
REQ-032 cmd_length=13 -> beats keep=0xFF/last=0, then keep=0x1F/last=1; bytes 5-7 of beat 2 read 0x00.
REQ-033 cmd_length=0 -> no m_tvalid, no msg_done, cmd_ready=1 the next cycle.
REQ-034 cmd_length=24 with m_tready low for 3 cycles on beat 2 -> beat 2 held stable, in_ready=0 during the stall, 3 beats in order, last keep=0xFF.
REQ-035 Commands 3 then 9 with m_tready=1 -> beats keep 0x07/last, 0xFF, 0x01/last; msg_done pulses twice.
REQ-036 cmd_length=20, rst low after beat 1 -> m_tvalid=0 at once; then cmd_length=1 -> single beat keep=0x01, last=1.
